clause_state_builder: RTL
=========================

CLAUSE_STATE_BUILDER -- requirements
Module: clause_state_builder

Interface
REQ-001 Parameter NUM_CLAUSES, default 16, number of clauses.
REQ-002 Parameter NUM_VARS_PER_CLAUSE, default 3, literal slots per clause.
REQ-003 Parameter NUM_VARS, default 16, number of problem variables; VAR_W = $clog2(NUM_VARS), CL_W = $clog2(NUM_CLAUSES), SL_W = $clog2(NUM_VARS_PER_CLAUSE).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 tbl_we  in  1  literal-table write strobe.
REQ-007 tbl_clause  in  CL_W  clause index written.
REQ-008 tbl_slot  in  SL_W  slot index within the clause.
REQ-009 tbl_var  in  VAR_W  variable referenced by the literal.
REQ-010 tbl_neg  in  1  1 = negated literal.
REQ-011 asg_valid  in  1  assignment update offered.
REQ-012 asg_ready  out  1  builder idle, accepts update.
REQ-013 asg_var  in  VAR_W  variable being updated.
REQ-014 asg_val  in  1  assigned Boolean value.
REQ-015 asg_clear  in  1  1 = unassign the variable (asg_val ignored).
REQ-016 clauses  out  NUM_CLAUSES*NUM_VARS_PER_CLAUSE  per-literal state, slot s of clause c at bit c*NUM_VARS_PER_CLAUSE+s; 0 = true/unassigned, 1 = false.
REQ-017 clauses_stable  out  1  clauses consistent with all accepted updates.
REQ-018 unsat_early  out  1  some clause has all slots false (see Configuration).

Function
REQ-019 FSM states IDLE and SCAN; IDLE -> SCAN on asg_valid && asg_ready; SCAN -> IDLE after the cycle processing clause NUM_CLAUSES-1.
REQ-020 asg_ready and clauses_stable shall be 1 exactly in IDLE.
REQ-021 On acceptance, asg_var/asg_val/asg_clear shall be latched; inputs are don't-care afterwards.
REQ-022 SCAN shall process one clause per cycle, index 0 upward; handshake at cycle T yields clause c updated at the edge ending cycle T+1+c; asg_ready returns high in cycle T+NUM_CLAUSES+1.
REQ-023 For each slot whose table var equals the latched var: new bit = ~clear & (val == neg); non-matching slots shall hold.
REQ-024 Clause counter CL_W bits; no wrap-around beyond NUM_CLAUSES-1 for non-power-of-two NUM_CLAUSES.
REQ-025 tbl_we in IDLE shall write {tbl_var, tbl_neg} and clear that slot's clauses bit to 0 at the same edge.
REQ-026 tbl_we in SCAN shall be ignored (no table or clauses change).
REQ-027 tbl_we and accepted asg in the same IDLE cycle: table write applies first; the scan uses the new entry.
REQ-028 Repeated assignment of the same value shall leave clauses unchanged; multiple slots matching in one clause all update in the same cycle.

Reset
REQ-029 rst_n low: state IDLE, clause counter 0, latched assignment 0, all table entries {var 0, neg 0}, clauses all 0, unsat_early 0; asg_ready and clauses_stable 1 from the first cycle after release.
REQ-030 Reset asserted mid-SCAN shall abort the scan immediately with the values of REQ-029; the aborted update has no effect.

Configuration
REQ-031 Macro CLAUSE_STATE_BUILDER_UNSAT_EN defined: unsat_early is a register set when a clause written during SCAN ends with all slots 1, cleared when an accepted update begins a new scan and re-evaluated over the new scan, and cleared by a table write.
REQ-032 Macro not defined: unsat_early tied to 0, no associated logic; port list unchanged.

Structure
REQ-033 Package clause_pkg holds default parameters, FSM state enum, and literal entry struct {var, neg}.
REQ-034 One sub-module, clause_slot_update: combinational, takes one clause's table entries, current bits, and latched assignment; returns updated bits per REQ-023.

Verification
REQ-035 Reset, load clause 0 = {x1, ~x2, x3}, assign x1=0 -> after 17 cycles clauses[2:0]=3'b001, clauses_stable=1.
REQ-036 Then assign x2=1, x3=0 -> clauses[2:0]=3'b111; with macro unsat_early=1, without 0.
REQ-037 Then unassign x2 -> clauses[2:0]=3'b101, unsat_early=0.
REQ-038 asg_valid held high continuously for 3 updates -> asg_ready low 16 cycles after each accept, exactly 3 handshakes in 51 cycles.
REQ-039 tbl_we during SCAN for clause 5 slot 0 -> table entry and clauses[15] unchanged; rst_n low at scan cycle 8 -> all outputs at reset values.
REQ-040 Same-cycle tbl_we (clause 0 slot 0 = x4) with accept of x4=0 -> clauses[0]=1 after scan.

Source files
------------

// File: rtl/clause_pkg.sv
// Shared types and defaults for the clause state builder.
// Holds parameter defaults, the scan FSM encoding and the literal table entry.
package clause_pkg;

  localparam int DEF_NUM_CLAUSES         = 16;
  localparam int DEF_NUM_VARS_PER_CLAUSE = 3;
  localparam int DEF_NUM_VARS            = 16;
  // Table entries carry a fixed-width variable field; narrower indices are zero-extended.
  localparam int MAX_VAR_W               = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  typedef struct packed {
    logic [MAX_VAR_W-1:0] lit_var;
    logic                 neg;
  } lit_entry_t;

endpackage

// File: rtl/clause_slot_update.sv
// Combinational per-clause literal update: every slot that references the latched
// variable gets its new false/true state, all other slots keep their current bit.
module clause_slot_update
  import clause_pkg::*;
#(
  parameter int NUM_VARS_PER_CLAUSE = DEF_NUM_VARS_PER_CLAUSE
) (
  input  lit_entry_t                     ents [NUM_VARS_PER_CLAUSE],
  input  logic [NUM_VARS_PER_CLAUSE-1:0] cur_bits,
  input  logic [MAX_VAR_W-1:0]           asg_var,
  input  logic                           asg_val,
  input  logic                           asg_clear,
  output logic [NUM_VARS_PER_CLAUSE-1:0] new_bits
);

  // Literal is false when assigned and the value matches its negation flag.
  always_comb begin
    new_bits = cur_bits;
    for (int s = 0; s < NUM_VARS_PER_CLAUSE; s++) begin
      if (ents[s].lit_var == asg_var) begin
        new_bits[s] = ~asg_clear & (asg_val == ents[s].neg);
      end else begin
        new_bits[s] = cur_bits[s];
      end
    end
  end

endmodule

// File: rtl/clause_state_builder.sv
// Builds per-literal false flags from a literal table and a stream of variable updates,
// one clause per cycle. Optional early-unsat flag enabled by CLAUSE_STATE_BUILDER_UNSAT_EN.
module clause_state_builder
  import clause_pkg::*;
#(
  parameter int NUM_CLAUSES         = DEF_NUM_CLAUSES,
  parameter int NUM_VARS_PER_CLAUSE = DEF_NUM_VARS_PER_CLAUSE,
  parameter int NUM_VARS            = DEF_NUM_VARS,
  localparam int VAR_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
  localparam int CL_W  = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1,
  localparam int SL_W  = (NUM_VARS_PER_CLAUSE > 1) ? $clog2(NUM_VARS_PER_CLAUSE) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       tbl_we,
  input  logic [CL_W-1:0]                            tbl_clause,
  input  logic [SL_W-1:0]                            tbl_slot,
  input  logic [VAR_W-1:0]                           tbl_var,
  input  logic                                       tbl_neg,
  input  logic                                       asg_valid,
  output logic                                       asg_ready,
  input  logic [VAR_W-1:0]                           asg_var,
  input  logic                                       asg_val,
  input  logic                                       asg_clear,
  output logic [NUM_CLAUSES*NUM_VARS_PER_CLAUSE-1:0] clauses,
  output logic                                       clauses_stable,
  output logic                                       unsat_early
);

  localparam int NB   = NUM_CLAUSES * NUM_VARS_PER_CLAUSE;
  localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;

  state_t                         state_r, state_nx;
  logic [CL_W-1:0]                cnt_r;
  logic [MAX_VAR_W-1:0]           lat_var_r;
  logic                           lat_val_r, lat_clear_r;
  lit_entry_t                     table_r [NUM_CLAUSES][NUM_VARS_PER_CLAUSE];
  lit_entry_t                     row_s   [NUM_VARS_PER_CLAUSE];
  logic [NB-1:0]                  clauses_r;
  logic [NUM_VARS_PER_CLAUSE-1:0] cur_bits_s, upd_bits_s;
  logic [BI_W-1:0]                scan_base_s, wr_bit_s;
  logic                           idle_s, accept_s, tbl_wr_s, cnt_last_s;

  assign idle_s      = (state_r == ST_IDLE);
  assign accept_s    = asg_valid & idle_s;
  // Out-of-range table indices (non-power-of-two sizes) are dropped.
  assign tbl_wr_s    = tbl_we & idle_s
                     & (int'(tbl_clause) < NUM_CLAUSES)
                     & (int'(tbl_slot) < NUM_VARS_PER_CLAUSE);
  assign cnt_last_s  = (cnt_r == CL_W'(NUM_CLAUSES - 1));
  assign scan_base_s = BI_W'(int'(cnt_r) * NUM_VARS_PER_CLAUSE);
  assign wr_bit_s    = BI_W'(int'(tbl_clause) * NUM_VARS_PER_CLAUSE + int'(tbl_slot));
  assign cur_bits_s  = clauses_r[scan_base_s +: NUM_VARS_PER_CLAUSE];

  // Select the table row of the clause currently being scanned.
  always_comb begin
    for (int s = 0; s < NUM_VARS_PER_CLAUSE; s++) begin
      row_s[s] = table_r[cnt_r][s];
    end
  end

  clause_slot_update #(
    .NUM_VARS_PER_CLAUSE(NUM_VARS_PER_CLAUSE)
  ) u_slot_update (
    .ents     (row_s),
    .cur_bits (cur_bits_s),
    .asg_var  (lat_var_r),
    .asg_val  (lat_val_r),
    .asg_clear(lat_clear_r),
    .new_bits (upd_bits_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (asg_valid) state_nx = ST_SCAN;
        else           state_nx = ST_IDLE;
      end
      ST_SCAN: begin
        if (cnt_last_s) state_nx = ST_IDLE;
        else            state_nx = ST_SCAN;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Clause counter and latched assignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= '0;
      lat_var_r   <= '0;
      lat_val_r   <= 1'b0;
      lat_clear_r <= 1'b0;
    end else begin
      if (state_r == ST_SCAN && !cnt_last_s) cnt_r <= cnt_r + 1'b1;
      else                                   cnt_r <= '0;
      if (accept_s) begin
        lat_var_r   <= MAX_VAR_W'(asg_var);
        lat_val_r   <= asg_val;
        lat_clear_r <= asg_clear;
      end
    end
  end

  // Literal table; written only while idle so a scan sees a frozen table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLAUSES; c++) begin
        for (int s = 0; s < NUM_VARS_PER_CLAUSE; s++) begin
          table_r[c][s] <= '0;
        end
      end
    end else if (tbl_wr_s) begin
      table_r[tbl_clause][tbl_slot] <= '{lit_var: MAX_VAR_W'(tbl_var), neg: tbl_neg};
    end
  end

  // Literal state: scan writes one clause per cycle, a table write resets its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clauses_r <= '0;
    end else if (state_r == ST_SCAN) begin
      clauses_r[scan_base_s +: NUM_VARS_PER_CLAUSE] <= upd_bits_s;
    end else if (tbl_wr_s) begin
      clauses_r[wr_bit_s] <= 1'b0;
    end
  end

`ifdef CLAUSE_STATE_BUILDER_UNSAT_EN
  logic unsat_r;

  // Early-unsat flag: re-evaluated over each scan, invalidated by table edits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unsat_r <= 1'b0;
    end else if (accept_s || tbl_wr_s) begin
      unsat_r <= 1'b0;
    end else if (state_r == ST_SCAN && (&upd_bits_s)) begin
      unsat_r <= 1'b1;
    end
  end

  assign unsat_early = unsat_r;
`else
  assign unsat_early = 1'b0;
`endif

  assign clauses        = clauses_r;
  assign asg_ready      = idle_s;
  assign clauses_stable = idle_s;

endmodule
